// File: rtl/shift_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : shift_arb_if
// Brief   : Two-port request / single-port result bundle for shift_arb.
// Rev     : 1.0  initial release
// ============================================================================
interface shift_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_data;
    logic [31:0] req0_amt;

    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_data;
    logic [31:0] req1_amt;

    logic        res_valid;
    logic        res_ready;
    logic        res_id;
    logic [31:0] res_data;
    logic        busy;

    modport master (
        output req0_valid, req0_op, req0_data, req0_amt,
        output req1_valid, req1_op, req1_data, req1_amt,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_data, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_data, req0_amt,
        input  req1_valid, req1_op, req1_data, req1_amt,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_arb.sv
`default_nettype none
// ============================================================================
// Module  : shift_arb
// Brief   : Round-robin arbiter and iterative controller for a shared shifter.
// Rev     : 1.0  initial release
// ============================================================================
module shift_arb #(
    parameter int STEP = 8
) (
    input  wire         clk,
    input  wire         rst_n,
    shift_arb_if.slave  bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    localparam logic [2:0] c_OP_SLL = 3'b000;
    localparam logic [2:0] c_OP_SRL = 3'b001;
    localparam logic [2:0] c_OP_SRA = 3'b010;
    localparam logic [2:0] c_OP_ROL = 3'b011;
    localparam logic [2:0] c_OP_ROR = 3'b100;

    localparam logic [5:0] c_STEP   = 6'(STEP);

    logic [1:0]  state_q, state_d;
    logic        last_q,  last_d;
    logic        id_q,    id_d;
    logic [2:0]  op_q,    op_d;
    logic [31:0] work_q,  work_d;
    logic [4:0]  rem_q,   rem_d;

    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic [2:0]  w_sel_op;
    logic [31:0] w_sel_data;
    logic [4:0]  w_sel_amt;
    logic [4:0]  w_n;
    logic [5:0]  w_inv_n;
    logic [31:0] w_shifted;

    assign w_idle = (state_q == c_IDLE);

    // On a tie the port that did not complete most recently wins.
    assign w_gnt0 = w_idle & rst_n & bus.req0_valid & (~bus.req1_valid | last_q);
    assign w_gnt1 = w_idle & rst_n & bus.req1_valid & (~bus.req0_valid | ~last_q);

    assign w_sel_op   = w_gnt1 ? bus.req1_op   : bus.req0_op;
    assign w_sel_data = w_gnt1 ? bus.req1_data : bus.req0_data;
    assign w_sel_amt  = (w_sel_op > c_OP_ROR) ? 5'd0
                      : (w_gnt1 ? bus.req1_amt[4:0] : bus.req0_amt[4:0]);

    assign w_n     = ({1'b0, rem_q} < c_STEP) ? rem_q : c_STEP[4:0];
    assign w_inv_n = 6'd32 - {1'b0, w_n};

    always_comb begin
        w_shifted = work_q;
        case (op_q)
            c_OP_SLL: w_shifted = work_q << w_n;
            c_OP_SRL: w_shifted = work_q >> w_n;
            c_OP_SRA: w_shifted = 32'($signed(work_q) >>> w_n);
            c_OP_ROL: w_shifted = (work_q << w_n) | (work_q >> w_inv_n);
            c_OP_ROR: w_shifted = (work_q >> w_n) | (work_q << w_inv_n);
            default:  w_shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        work_d  = work_q;
        rem_d   = rem_q;
        case (state_q)
            c_IDLE: begin
                if (w_gnt0 | w_gnt1) begin
                    op_d    = w_sel_op;
                    work_d  = w_sel_data;
                    rem_d   = w_sel_amt;
                    id_d    = w_gnt1;
                    state_d = (w_sel_amt == 5'd0) ? c_DONE : c_SHIFT;
                end
            end
            c_SHIFT: begin
                work_d = w_shifted;
                rem_d  = rem_q - w_n;
                if (rem_q == w_n) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                if (bus.res_ready) begin
                    state_d = c_IDLE;
                    last_d  = id_q;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= 3'd0;
            work_q  <= 32'd0;
            rem_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.res_valid  = (state_q == c_DONE);
    assign bus.res_id     = id_q;
    assign bus.res_data   = work_q;
    assign bus.busy       = ~w_idle;

endmodule
`default_nettype wire

// File: doc/shift_arb.md
# shift_arb

Multi-cycle controller and two-port arbiter for the ALU shift unit. Two requesters (port 0: ALU execute, port 1: address/immediate path) share one iterative shifter. The block grants the shifter round-robin, captures one operation, and shifts by at most STEP bits per cycle until the full amount is applied. It returns the result with the requester id over a valid/ready handshake.

## Interface
- STEP, default 8: maximum shift distance applied per cycle. Legal values are 1, 2, 4, 8, 16 and 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- req0_valid  in  1  port 0 has an operation.
- req0_ready  out  1  port 0 operation accepted this cycle.
- req0_op  in  3  port 0 opcode.
- req0_data  in  32  port 0 operand.
- req0_amt  in  32  port 0 shift amount; only bits [4:0] are used.
- req1_valid, req1_ready, req1_op, req1_data, req1_amt: same widths and meaning, for port 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_id  out  1  port that issued the result.
- res_data  out  32  shifted result.
- busy  out  1  high whenever state != IDLE.

## Operation
- Opcodes:
  - 000 SLL: shift left logical, zero fill.
  - 001 SRL: shift right logical, zero fill.
  - 010 SRA: shift right arithmetic; bit 31 is replicated.
  - 011 ROL: rotate left.
  - 100 ROR: rotate right.
  - 101–111: pass-through. Handled as amount 0; the result equals the operand.
- Amount is taken modulo 32: amt[4:0] only. Example: 32 gives 0, 0x25 gives 5.
- FSM states:
  - IDLE:
    - Arbitrate between the two ports.
    - On accept, capture op, data, amt[4:0] and id.
    - Go to SHIFT if the effective amount is nonzero.
    - Go to DONE if the amount is 0 or the opcode is pass-through.
  - SHIFT:
    - Each cycle, shift the working register by n = min(rem, STEP) using the captured op, then set rem -= n.
    - When rem reaches 0 this cycle, go to DONE.
  - DONE:
    - res_valid=1. Go to IDLE on res_valid & res_ready, and set last = res_id.
- Arbitration (IDLE only, combinational readies):
  - Exactly one reqX_ready is high, and only when its reqX_valid is high.
  - If both ports are valid, grant the port not in `last`.
  - If one port is valid, grant it.
  - reqX_ready is always 0 in SHIFT and in DONE.
  - reqX_ready is 0 while rst_n=0.
- A requester must hold valid, op, data and amt stable until it sees ready. Changing them earlier is undefined.
- res_data and res_id hold stable while res_valid & !res_ready.
- SRA and rotates must be exact across steps: a rotate by n done in k steps equals one rotate by n.
- No new operation is accepted in the cycle the result is consumed; it is accepted on the next IDLE cycle.

## Timing
- Reset values:
  - state=IDLE, last=1 (port 0 wins the first tie).
  - res_valid=0, res_id=0, res_data=0x0000_0000, busy=0, req0_ready=req1_ready=0.
- Accept happens at edge T (reqX_valid & reqX_ready sampled high).
- res_valid first high after edge T+1+ceil(amt/STEP). With STEP=8:
  - amt 0 gives T+1.
  - amt 1–8 gives T+2.
  - amt 31 gives T+5.
- The SHIFT state occupies exactly ceil(amt/STEP) cycles.
- Minimum spacing between accepts with res_ready held high: latency + 1 cycles.
- Reset mid-operation (rst_n low at any edge in SHIFT or DONE):
  - The operation is discarded and no result is ever presented.
  - The block is back in IDLE with the reset values at the next edge.
  - Readies may assert in the first cycle after rst_n returns high.
- busy rises the cycle after accept. It falls the cycle after the result handshake.

## Test plan
- Single request: req0 SLL 0x0000_0001, amt 4, res_ready=1. Required response: res_data 0x0000_0010, res_id 0, res_valid at T+2, busy high for 2 cycles.
- Tie and round-robin: after reset, both ports valid. req0 is ROR 0x8000_0001 amt 1; req1 is SRA 0x8000_0000 amt 31. Required response, in order:
  - first result 0xC000_0000, id 0;
  - then 0xFFFF_FFFF, id 1, res_valid 5 cycles after its accept.
  - Then re-issue both requests: port 1 must not win. `last` is now 1, so port 0 is granted first again.
- Amount masking and pass-through:
  - SRL 0x8000_0000 with amt 0x20 returns 0x8000_0000 at T+1.
  - amt 0x25 behaves as 5.
  - op 111 returns the operand unchanged at T+1.
- Multi-step rotate: ROL 0x1234_5678 with amt 12 (STEP=8) returns 0x4567_8123 after 2 SHIFT cycles, res_valid at T+3. Repeat with STEP=1: res_valid at T+13, same data.
- Backpressure: hold res_ready=0 for 5 cycles with req1_valid high. Required response:
  - res_data and res_id stay constant;
  - req0_ready and req1_ready stay 0;
  - the handshake completes on the cycle res_ready rises;
  - req1 is accepted on the following cycle.
- Reset mid-op: accept SRA with amt 31, then drive rst_n=0 for 1 edge during SHIFT. Required response: res_valid never rises for that operation, busy=0 after the edge, and a new req0 is accepted normally afterwards.
